// File: rtl/sm3_arb_pkg.sv
// Shared definitions for the SM3 message arbiter: one-hot FSM encoding and defaults.
// The grant index width is derived from the requester count by the modules themselves.
package sm3_arb_pkg;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_DW      = 32;

    localparam int         ST_W     = 3;
    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_XFER  = 3'b010;
    localparam logic [2:0] ST_DRAIN = 3'b100;

    // Pointer that follows owner idx, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sm3_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
// Shared by the message arbiter and the future result arbiters.
module sm3_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any_req
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt_idx      = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/sm3_msg_arb.sv
// Round-robin arbiter sharing one sm3_pad_core input between NUM_REQ message sources.
// Grants a whole message and holds it until the pad core reports padding complete.
module sm3_msg_arb
    import sm3_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int DW      = ARB_DW,
    parameter int BW      = DW / 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ*DW-1:0] req_d_i,
    input  logic [NUM_REQ*BW-1:0] req_vld_byte_i,
    input  logic [NUM_REQ-1:0]    req_vld_i,
    input  logic [NUM_REQ-1:0]    req_lst_i,
    output logic [NUM_REQ-1:0]    req_rdy_o,
    output logic [NUM_REQ-1:0]    grnt_o,
    output logic [IDW-1:0]        grnt_id_o,
    output logic [DW-1:0]         pad_msg_d_o,
    output logic [BW-1:0]         pad_msg_vld_byte_o,
    output logic                  pad_msg_vld_o,
    output logic                  pad_msg_lst_o,
    input  logic                  pad_msg_rdy_i,
    input  logic                  pad_otpt_lst_i,
    output logic                  busy_o,
    output logic                  proto_err_o
);

    logic [ST_W-1:0]    state;
    logic [IDW-1:0]     rr_ptr;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    logic               in_xfer;
    logic [DW-1:0]      sel_d;
    logic [BW-1:0]      sel_vb;
    logic               sel_vld;
    logic               sel_lst;
    logic               acc_lst;

    sm3_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req     (req_vld_i),
        .ptr     (rr_ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    // Single mux level from the owner's lanes; the pad core registers its inputs.
    always_comb begin
        sel_d   = '0;
        sel_vb  = '0;
        sel_vld = 1'b0;
        sel_lst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grnt_id_o == IDW'(k)) begin
                sel_d   = req_d_i[k*DW +: DW];
                sel_vb  = req_vld_byte_i[k*BW +: BW];
                sel_vld = req_vld_i[k];
                sel_lst = req_lst_i[k];
            end
        end
    end

    assign in_xfer = (state == ST_XFER);

    // The pad core cannot stall a valid beat, so valid is only raised when it is ready.
    assign pad_msg_vld_o      = in_xfer & sel_vld & pad_msg_rdy_i;
    assign pad_msg_lst_o      = pad_msg_vld_o & sel_lst;
    assign pad_msg_d_o        = in_xfer ? sel_d  : '0;
    assign pad_msg_vld_byte_o = in_xfer ? sel_vb : '0;
    assign req_rdy_o          = (in_xfer && pad_msg_rdy_i) ? grnt_o : '0;
    assign busy_o             = (state != ST_IDLE);
    assign acc_lst            = pad_msg_vld_o & sel_lst;

    // grnt_id_o is deliberately left untouched on leaving DRAIN so the hash result can still be tagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grnt_o      <= '0;
            grnt_id_o   <= '0;
            rr_ptr      <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (pad_otpt_lst_i && (state != ST_DRAIN)) begin
                proto_err_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grnt_o    <= pick_oh;
                        grnt_id_o <= pick_idx;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (acc_lst) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pad_otpt_lst_i) begin
                        rr_ptr <= IDW'(rr_next(int'(grnt_id_o), NUM_REQ));
                        grnt_o <= '0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    grnt_o <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_msg_arb.sv
// Directed bench for sm3_msg_arb: requester drivers, a pad-core stub and a scoreboard
// monitor that checks every forwarded beat against hand-written expected messages.
module tb_sm3_msg_arb;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int BW      = 4;
    localparam int IDW     = 2;
    localparam int DEPTH   = 16;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  d;
        logic [BW-1:0]  vb;
        logic           lst;
    } beat_t;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ*DW-1:0] req_d_i;
    logic [NUM_REQ*BW-1:0] req_vld_byte_i;
    logic [NUM_REQ-1:0]    req_vld_i;
    logic [NUM_REQ-1:0]    req_lst_i;
    logic [NUM_REQ-1:0]    req_rdy_o;
    logic [NUM_REQ-1:0]    grnt_o;
    logic [IDW-1:0]        grnt_id_o;
    logic [DW-1:0]         pad_msg_d_o;
    logic [BW-1:0]         pad_msg_vld_byte_o;
    logic                  pad_msg_vld_o;
    logic                  pad_msg_lst_o;
    logic                  pad_msg_rdy_i;
    logic                  pad_otpt_lst_i;
    logic                  busy_o;
    logic                  proto_err_o;

    beat_t       expQ[$];
    logic [DW-1:0] memD [NUM_REQ][DEPTH];
    logic [BW-1:0] memB [NUM_REQ][DEPTH];
    logic          memL [NUM_REQ][DEPTH];
    int          cnt [NUM_REQ] = '{default: 0};
    int          pos [NUM_REQ] = '{default: 0};
    int          checks    = 0;
    int          errors    = 0;
    int          manualReq = 0;

    sm3_msg_arb #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW),
        .BW      (BW),
        .IDW     (IDW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_d_i            (req_d_i),
        .req_vld_byte_i     (req_vld_byte_i),
        .req_vld_i          (req_vld_i),
        .req_lst_i          (req_lst_i),
        .req_rdy_o          (req_rdy_o),
        .grnt_o             (grnt_o),
        .grnt_id_o          (grnt_id_o),
        .pad_msg_d_o        (pad_msg_d_o),
        .pad_msg_vld_byte_o (pad_msg_vld_byte_o),
        .pad_msg_vld_o      (pad_msg_vld_o),
        .pad_msg_lst_o      (pad_msg_lst_o),
        .pad_msg_rdy_i      (pad_msg_rdy_i),
        .pad_otpt_lst_i     (pad_otpt_lst_i),
        .busy_o             (busy_o),
        .proto_err_o        (proto_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Queue one beat on requester k; the driver presents it from the next cycle.
    task automatic applyStimulus(input int k, input logic [DW-1:0] d, input logic [BW-1:0] vb, input logic lst);
        memD[k][cnt[k]] = d;
        memB[k][cnt[k]] = vb;
        memL[k][cnt[k]] = lst;
        cnt[k]++;
    endtask

    task automatic expectBeat(input int k, input logic [DW-1:0] d, input logic [BW-1:0] vb, input logic lst);
        beat_t b;
        b.id  = IDW'(k);
        b.d   = d;
        b.vb  = vb;
        b.lst = lst;
        expQ.push_back(b);
    endtask

    task automatic sendMsg(input int k, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) applyStimulus(k, base + DW'(i), 4'hF, (i == n - 1));
    endtask

    task automatic expectMsg(input int k, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) expectBeat(k, base + DW'(i), 4'hF, (i == n - 1));
    endtask

    task automatic clearMsgs();
        for (int k = 0; k < NUM_REQ; k++) cnt[k] = pos[k];
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 400 && (expQ.size() != 0 || busy_o); i++) tick(1);
        checkOutput(name, 64'(expQ.size() == 0 && !busy_o), 64'd1);
    endtask

    // Requester drivers: advance a lane only on a handshake seen while signals are stable.
    initial begin
        logic [NUM_REQ-1:0] took;
        req_d_i        = '0;
        req_vld_byte_i = '0;
        req_vld_i      = '0;
        req_lst_i      = '0;
        forever begin
            @(negedge clk);
            took = req_vld_i & req_rdy_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (took[k]) pos[k]++;
                if (pos[k] < cnt[k]) begin
                    req_d_i[k*DW +: DW]        = memD[k][pos[k]];
                    req_vld_byte_i[k*BW +: BW] = memB[k][pos[k]];
                    req_lst_i[k]               = memL[k][pos[k]];
                    req_vld_i[k]               = 1'b1;
                end else begin
                    req_d_i[k*DW +: DW]        = '0;
                    req_vld_byte_i[k*BW +: BW] = '0;
                    req_lst_i[k]               = 1'b0;
                    req_vld_i[k]               = 1'b0;
                end
            end
        end
    end

    // Pad-core stub: reports padding complete three cycles after the last beat, or on demand.
    initial begin
        int pend;
        int seen;
        pend           = 0;
        seen           = 0;
        pad_otpt_lst_i = 1'b0;
        forever begin
            @(negedge clk);
            if (pad_msg_vld_o && pad_msg_lst_o) pend = 3;
            @(posedge clk);
            #1;
            if (pend > 0) begin
                pend--;
                pad_otpt_lst_i = (pend == 0);
            end else begin
                pad_otpt_lst_i = (manualReq != seen);
                seen           = manualReq;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        beat_t act;
        beat_t exp;
        forever begin
            @(negedge clk);
            if (pad_msg_vld_o) begin
                act.id  = grnt_id_o;
                act.d   = pad_msg_d_o;
                act.vb  = pad_msg_vld_byte_o;
                act.lst = pad_msg_lst_o;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", act);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("beat", 64'(act), 64'(exp));
                end
            end
            checkOutput("rdy_owner_only", 64'(req_rdy_o & ~grnt_o), 64'd0);
            checkOutput("lst_qualified", 64'(pad_msg_lst_o & ~pad_msg_vld_o), 64'd0);
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b1;
        pad_msg_rdy_i = 1'b1;
        tick(3);
        checkOutput("rst_grnt",    64'(grnt_o),        64'd0);
        checkOutput("rst_grnt_id", 64'(grnt_id_o),     64'd0);
        checkOutput("rst_busy",    64'(busy_o),        64'd0);
        checkOutput("rst_err",     64'(proto_err_o),   64'd0);
        checkOutput("rst_vld",     64'(pad_msg_vld_o), 64'd0);
        rst = 1'b0;
        tick(1);

        $display("[TB] contention: four 2-beat messages, rr_ptr=0");
        for (int k = 0; k < NUM_REQ; k++) sendMsg(k, 2, 32'hA000_0000 + DW'(k * 16));
        for (int k = 0; k < NUM_REQ; k++) expectMsg(k, 2, 32'hA000_0000 + DW'(k * 16));
        waitDone("t2_done");

        $display("[TB] single requester with arbitration bubble");
        applyStimulus(0, 32'h6162_6364, 4'hF, 1'b0);
        applyStimulus(0, 32'h6566_6768, 4'hF, 1'b0);
        applyStimulus(0, 32'h6900_0000, 4'b1000, 1'b1);
        expectBeat(0, 32'h6162_6364, 4'hF, 1'b0);
        expectBeat(0, 32'h6566_6768, 4'hF, 1'b0);
        expectBeat(0, 32'h6900_0000, 4'b1000, 1'b1);
        tick(1);
        checkOutput("t1_bubble_busy", 64'(busy_o),        64'd0);
        checkOutput("t1_bubble_vld",  64'(pad_msg_vld_o), 64'd0);
        checkOutput("t1_bubble_rdy",  64'(req_rdy_o),     64'd0);
        tick(1);
        checkOutput("t1_grnt",    64'(grnt_o),        64'd1);
        checkOutput("t1_grnt_id", 64'(grnt_id_o),     64'd0);
        checkOutput("t1_busy",    64'(busy_o),        64'd1);
        checkOutput("t1_vld",     64'(pad_msg_vld_o), 64'd1);
        waitDone("t1_done");

        $display("[TB] rr_ptr=1 after req0: req0 and req1 pending");
        sendMsg(0, 1, 32'hB000_0000);
        sendMsg(1, 1, 32'hB100_0000);
        expectMsg(1, 1, 32'hB100_0000);
        expectMsg(0, 1, 32'hB000_0000);
        waitDone("t1b_done");

        $display("[TB] fairness wrap: req2 then req1/req3");
        sendMsg(2, 2, 32'hC200_0000);
        expectMsg(2, 2, 32'hC200_0000);
        waitDone("t3a_done");
        sendMsg(1, 2, 32'hC100_0000);
        sendMsg(3, 2, 32'hC300_0000);
        expectMsg(3, 2, 32'hC300_0000);
        expectMsg(1, 2, 32'hC100_0000);
        waitDone("t3b_done");

        $display("[TB] backpressure mid-message");
        sendMsg(2, 4, 32'hD200_0000);
        expectMsg(2, 4, 32'hD200_0000);
        for (int i = 0; i < 20 && !pad_msg_vld_o; i++) tick(1);
        checkOutput("t4_first_beat", 64'(pad_msg_vld_o), 64'd1);
        tick(1);
        pad_msg_rdy_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_stall_vld", 64'(pad_msg_vld_o), 64'd0);
            checkOutput("t4_stall_rdy", 64'(req_rdy_o),     64'd0);
            tick(1);
        end
        pad_msg_rdy_i = 1'b1;
        waitDone("t4_done");

        $display("[TB] protocol error in XFER, then reset");
        pad_msg_rdy_i = 1'b0;
        sendMsg(0, 2, 32'hE000_0000);
        tick(3);
        checkOutput("t5_busy", 64'(busy_o), 64'd1);
        checkOutput("t5_grnt", 64'(grnt_o), 64'd1);
        manualReq++;
        tick(2);
        checkOutput("t5_err",       64'(proto_err_o), 64'd1);
        checkOutput("t5_grnt_kept", 64'(grnt_o),      64'd1);
        expectBeat(0, 32'hE000_0000, 4'hF, 1'b0);
        pad_msg_rdy_i = 1'b1;
        #1;
        checkOutput("t5_still_xfer", 64'(req_rdy_o), 64'd1);
        tick(1);
        pad_msg_rdy_i = 1'b0;
        rst           = 1'b1;
        clearMsgs();
        tick(1);
        rst = 1'b0;
        checkOutput("t5_rst_grnt", 64'(grnt_o),      64'd0);
        checkOutput("t5_rst_busy", 64'(busy_o),      64'd0);
        checkOutput("t5_rst_err",  64'(proto_err_o), 64'd0);
        pad_msg_rdy_i = 1'b1;
        tick(2);
        checkOutput("t5_idle_after", 64'(busy_o), 64'd0);

        $display("[TB] single-beat message with new requests at pad_otpt_lst");
        sendMsg(1, 1, 32'hF100_0000);
        expectMsg(1, 1, 32'hF100_0000);
        for (int i = 0; i < 20 && !pad_msg_vld_o; i++) tick(1);
        checkOutput("t6_xfer_seen", 64'(pad_msg_vld_o), 64'd1);
        tick(1);
        checkOutput("t6_drain_rdy",  64'(req_rdy_o), 64'd0);
        checkOutput("t6_drain_busy", 64'(busy_o),    64'd1);
        sendMsg(0, 1, 32'hF000_0000);
        sendMsg(3, 1, 32'hF300_0000);
        expectMsg(3, 1, 32'hF300_0000);
        expectMsg(0, 1, 32'hF000_0000);
        for (int i = 0; i < 20 && !pad_otpt_lst_i; i++) tick(1);
        checkOutput("t6_padlst_seen", 64'(pad_otpt_lst_i), 64'd1);
        checkOutput("t6_padlst_busy", 64'(busy_o),         64'd1);
        tick(1);
        checkOutput("t6_idle_busy", 64'(busy_o), 64'd0);
        checkOutput("t6_idle_grnt", 64'(grnt_o), 64'd0);
        tick(1);
        checkOutput("t6_regrant_busy", 64'(busy_o),    64'd1);
        checkOutput("t6_regrant_grnt", 64'(grnt_o),    64'd8);
        checkOutput("t6_regrant_id",   64'(grnt_id_o), 64'd3);
        waitDone("t6_done");

        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm3_msg_arb.md
Name: sm3_msg_arb

Overview:
- Round-robin message arbiter that shares one sm3_pad_core input between NUM_REQ independent message sources.
- Grants at whole-message granularity and forwards the granted source's beats to the pad core.
- Holds the grant until the pad core signals end of padding (pad_otpt_lst), so messages never interleave.
- Sits directly in front of sm3_pad_core in the multi-channel SM3 top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 32, data width; equals INPT_DW (32 or 64).
- BW, DW/8, byte-valid width.
- IDW, $clog2(NUM_REQ), grant-index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_d_i  in  NUM_REQ*DW  message data; requester k occupies bits [k*DW +: DW]
- req_vld_byte_i  in  NUM_REQ*BW  byte valids per requester
- req_vld_i  in  NUM_REQ  beat valid per requester
- req_lst_i  in  NUM_REQ  last beat of message per requester
- req_rdy_o  out  NUM_REQ  beat accepted from requester k when req_vld_i[k] & req_rdy_o[k]
- grnt_o  out  NUM_REQ  one-hot current owner (registered)
- grnt_id_o  out  IDW  binary index of owner, for tagging the hash result
- pad_msg_d_o  out  DW  to msg_inpt_d_i
- pad_msg_vld_byte_o  out  BW  to msg_inpt_vld_byte_i
- pad_msg_vld_o  out  1  to msg_inpt_vld_i
- pad_msg_lst_o  out  1  to msg_inpt_lst_i
- pad_msg_rdy_i  in  1  from msg_inpt_rdy_o
- pad_otpt_lst_i  in  1  from pad_otpt_lst_o (message padding complete)
- busy_o  out  1  high in any state other than IDLE
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, grnt_o=0, grnt_id_o=0, rr_ptr=0, proto_err_o=0. All other outputs are 0 through decode.
- Reset asserted mid-message drops the grant immediately. The pad core must be reset together with this block.
- FSM states:
  - IDLE: if any req_vld_i, pick the winner by round robin starting at rr_ptr (first set bit at or after rr_ptr, wrapping). Register grnt_o and grnt_id_o, then go to XFER. Otherwise stay in IDLE. No beat is accepted in IDLE; there is a 1-cycle arbitration bubble.
  - XFER: g = grnt_id_o.
    - req_rdy_o[g] = pad_msg_rdy_i; all other req_rdy_o bits are 0.
    - pad_msg_vld_o = req_vld_i[g] & pad_msg_rdy_i. The pad core has no backpressure on vld, so vld is gated by rdy.
    - pad_msg_d_o, pad_msg_vld_byte_o and pad_msg_lst_o are muxed from requester g. pad_msg_lst_o is qualified by pad_msg_vld_o.
    - An accepted beat with req_lst_i[g]=1 moves the FSM to DRAIN.
  - DRAIN: all req_rdy_o=0 and pad_msg_vld_o=0; wait for pad_otpt_lst_i.
    - When pad_otpt_lst_i arrives: set rr_ptr=(g+1) mod NUM_REQ, clear grnt_o, go to IDLE.
- Forward path from req_* to pad_msg_* is purely combinational (one mux level, no added latency); the pad core registers its inputs.
- Round-robin fairness: every requester holding req_vld_i waits at most NUM_REQ-1 messages. rr_ptr advances only when a message completes.
- A requester that deasserts req_vld_i mid-message keeps the grant. Zero-valid gaps are legal.
- Simultaneous events:
  - pad_otpt_lst_i in DRAIN together with new requests: go to IDLE this cycle and arbitrate next cycle, using the updated rr_ptr.
  - pad_otpt_lst_i in IDLE or XFER sets proto_err_o. The FSM does not change state on it.
- Single-beat message (first beat has lst): XFER lasts one cycle, then the FSM goes to DRAIN.
- grnt_id_o is stable from XFER entry until the cycle after pad_otpt_lst_i.

Decomposition:
- Shared package sm3_arb_pkg holds the FSM state encoding (one-hot: IDLE=3'b001, XFER=3'b010, DRAIN=3'b100) and the NUM_REQ default.
- DW comes from the existing sm3_cfg.v defines (INPT_DW).
- One sub-module is natural: sm3_rr_pick, a combinational round-robin priority picker. Inputs are req vector and ptr; outputs are one-hot plus index plus any_req. It is reused by future output/result arbiters.

Test Plan:
- Single requester: req0 sends 3 words 0x61626364, 0x65666768, 0x69000000 (lst, vld_byte=4'b1000). Expect the 1-cycle bubble, then 3 forwarded beats with grnt_id_o=0. Expect DRAIN until pad_otpt_lst_i, then IDLE with rr_ptr=1.
- Contention: req0..req3 all valid in the same cycle, each with 2-beat messages. Expect grant order 0,1,2,3, with no beat of another requester appearing before the previous pad_otpt_lst_i.
- Fairness wrap: rr_ptr=3 after a req2 message; req1 and req3 pending. Expect req3 granted first, then req1.
- Backpressure: drive pad_msg_rdy_i=0 for 4 cycles mid-message. Expect pad_msg_vld_o=0 and req_rdy_o[g]=0 throughout, and the data sequence unchanged and un-duplicated after rdy returns.
- Protocol error and reset: pulse pad_otpt_lst_i in XFER. Expect proto_err_o=1 and the FSM still in XFER. Assert rst for 1 cycle. Expect grnt_o=0, busy_o=0, proto_err_o=0 on the next edge.
- Single-beat message plus a simultaneous new request during the pad_otpt_lst_i cycle: expect the next grant exactly 1 cycle after the IDLE entry.
